wb_arbiter2: RTL

Two-master, one-slave Wishbone SPEC B4 (pipelined) arbiter that shares one block device (acquisition SRAM) between two requesters. Requester A is the capture/write path; requester B is the streaming read path, i.e. the address-generating stream unit that feeds the SPI readout. Grants are registered, tenures are bounded by an optional transfer budget, and outstanding transfers are tracked so that no tenure ends with an acknowledge still in flight.

---
 rtl/wb_arbiter2.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
//
// Two-master, one-slave pipelined Wishbone arbiter. It shares a single block
// device (the acquisition SRAM) between requester A (capture/write path) and
// requester B (streaming read path feeding the SPI readout).
//
// Grants are registered. While a requester owns the bus, its request and the
// slave's responses pass through with no added latency. An optional budget
// (LIMIT) bounds each tenure. A tenure that hits its budget drains its
// outstanding transfers before it releases the bus, so no acknowledge is
// left in flight when ownership moves. At least one idle cycle separates any
// two tenures.
//
// Parameters
//   WIDTH  data bus width
//   WBITS  address width
//   LIMIT  accepted requests per tenure before draining (0 = unlimited)
//   PRIO   0 = round-robin on ties, 1 = A always wins ties
//   OBITS  width of the outstanding-transfer counter
//   DELAY  register delay for behavioural simulation models; unused here
//
// Ports
//   clk_i, rst_ni             clock; asynchronous active-low reset
//   a_cyc/stb/we/adr/dat_i    requester A bus request
//   a_ack/wat/rty/err_o       requester A responses
//   a_dat_o                   read data to A (always m_dat_i)
//   b_*                       same set for requester B
//   m_cyc/stb/we/adr/dat_o    request to the block device
//   m_ack/wat/rty/err_i       responses from the block device
//   m_dat_i                   read data from the block device
//   gnt_o                     registered one-hot owner {B,A}; 00 when idle
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int WIDTH = 8,
  parameter int WBITS = 10,
  parameter int LIMIT = 0,
  parameter int PRIO  = 0,
  parameter int OBITS = 4,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             a_cyc_i,
  input  logic             a_stb_i,
  input  logic             a_we_i,
  input  logic [WBITS-1:0] a_adr_i,
  input  logic [WIDTH-1:0] a_dat_i,
  output logic             a_ack_o,
  output logic             a_wat_o,
  output logic             a_rty_o,
  output logic             a_err_o,
  output logic [WIDTH-1:0] a_dat_o,

  input  logic             b_cyc_i,
  input  logic             b_stb_i,
  input  logic             b_we_i,
  input  logic [WBITS-1:0] b_adr_i,
  input  logic [WIDTH-1:0] b_dat_i,
  output logic             b_ack_o,
  output logic             b_wat_o,
  output logic             b_rty_o,
  output logic             b_err_o,
  output logic [WIDTH-1:0] b_dat_o,

  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [WBITS-1:0] m_adr_o,
  output logic [WIDTH-1:0] m_dat_o,
  input  logic             m_ack_i,
  input  logic             m_wat_i,
  input  logic             m_rty_i,
  input  logic             m_err_i,
  input  logic [WIDTH-1:0] m_dat_i,

  output logic [1:0]       gnt_o
);

  // Tenure counter only needs to reach LIMIT; one bit when unlimited.
  localparam int CBITS = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CBITS-1:0] LIMIT_C = CBITS'(LIMIT);
  localparam logic [OBITS-1:0] OMAX    = {OBITS{1'b1}};

  // DELAY only shapes behavioural models elsewhere; the synthesizable
  // datapath carries no extra register stage for it.
  if (DELAY > 0) begin : g_sim_delay
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             owner, owner_next;   // 0 = A, 1 = B
  logic             last, last_next;     // previous owner, for round-robin
  logic [OBITS-1:0] outstanding, outstanding_next;
  logic [CBITS-1:0] count, count_next;
  logic [1:0]       gnt, gnt_next;

  // Owner-selected request lines.
  logic             own_cyc;
  logic             own_stb;
  logic             own_we;
  logic [WBITS-1:0] own_adr;
  logic [WIDTH-1:0] own_dat;

  // Responses routed to the current owner.
  logic             r_ack;
  logic             r_wat;
  logic             r_rty;
  logic             r_err;

  logic             own_path;     // a tenure is active (BUSY or DRAIN)
  logic             sat;          // outstanding counter is full
  logic             accept;       // slave accepted a request this cycle
  logic             resp;         // slave terminated a transfer this cycle
  logic             dec;
  logic [OBITS-1:0] out_upd;      // outstanding after this cycle's events
  logic [CBITS-1:0] count_inc;
  logic             pick;         // requester chosen in IDLE

  assign own_cyc  = owner ? b_cyc_i : a_cyc_i;
  assign own_stb  = owner ? b_stb_i : a_stb_i;
  assign own_we   = owner ? b_we_i  : a_we_i;
  assign own_adr  = owner ? b_adr_i : a_adr_i;
  assign own_dat  = owner ? b_dat_i : a_dat_i;

  assign own_path = (state != IDLE);
  assign sat      = (outstanding == OMAX);
  assign accept   = m_stb_o & ~m_wat_i;
  assign resp     = m_ack_i | m_err_i | m_rty_i;

  // A response with nothing outstanding only counts when it pairs with a
  // same-cycle accept (zero-latency slave); otherwise it must not wrap.
  assign dec      = own_path & resp & ((outstanding != '0) | accept);
  assign count_inc = count + CBITS'(1);

  always_comb begin
    out_upd = outstanding;
    unique case ({accept, dec})
      2'b10:   out_upd = outstanding + OBITS'(1);
      2'b01:   out_upd = outstanding - OBITS'(1);
      default: out_upd = outstanding;
    endcase
  end

  // -------------------------------------------------------------------------
  // Slave-side request and owner-side response routing
  // -------------------------------------------------------------------------
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    r_ack   = 1'b0;
    r_wat   = 1'b0;
    r_rty   = 1'b0;
    r_err   = 1'b0;

    unique case (state)
      BUSY: begin
        m_cyc_o = own_cyc;
        // A full counter holds new requests back until something retires.
        m_stb_o = own_stb & ~sat;
        m_we_o  = own_we;
        m_adr_o = own_adr;
        m_dat_o = own_dat;
        r_ack   = m_ack_i;
        r_rty   = m_rty_i;
        r_err   = m_err_i;
        r_wat   = m_wat_i | sat;
      end
      DRAIN: begin
        // Cycle stays open so the remaining responses can land; no new
        // strobes go out and the owner is stalled.
        m_cyc_o = 1'b1;
        m_stb_o = 1'b0;
        m_we_o  = own_we;
        m_adr_o = own_adr;
        m_dat_o = own_dat;
        r_ack   = m_ack_i;
        r_rty   = m_rty_i;
        r_err   = m_err_i;
        r_wat   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Non-owners (and everybody while idle) are simply stalled while they
  // hold cyc; they never see a termination.
  assign a_ack_o = own_path & ~owner & r_ack;
  assign a_rty_o = own_path & ~owner & r_rty;
  assign a_err_o = own_path & ~owner & r_err;
  assign a_wat_o = (own_path & ~owner) ? r_wat : a_cyc_i;

  assign b_ack_o = own_path & owner & r_ack;
  assign b_rty_o = own_path & owner & r_rty;
  assign b_err_o = own_path & owner & r_err;
  assign b_wat_o = (own_path & owner) ? r_wat : b_cyc_i;

  assign a_dat_o = m_dat_i;
  assign b_dat_o = m_dat_i;
  assign gnt_o   = gnt;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state;
    owner_next       = owner;
    last_next        = last;
    outstanding_next = outstanding;
    count_next       = count;
    gnt_next         = gnt;
    pick             = 1'b0;

    unique case (state)
      IDLE: begin
        if (a_cyc_i | b_cyc_i) begin
          if (a_cyc_i & b_cyc_i) begin
            pick = (PRIO == 1) ? 1'b0 : ~last;
          end else begin
            pick = ~a_cyc_i;
          end
          state_next       = BUSY;
          owner_next       = pick;
          count_next       = '0;
          outstanding_next = '0;
          gnt_next         = pick ? 2'b10 : 2'b01;
        end
      end

      BUSY: begin
        if (!own_cyc) begin
          // Abort: whatever is in flight is abandoned.
          state_next       = IDLE;
          outstanding_next = '0;
          last_next        = owner;
          gnt_next         = 2'b00;
        end else begin
          outstanding_next = out_upd;
          if (accept) begin
            count_next = count_inc;
          end
          if ((LIMIT > 0) && accept && (count_inc == LIMIT_C)) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (!own_cyc) begin
          state_next       = IDLE;
          outstanding_next = '0;
          last_next        = owner;
          gnt_next         = 2'b00;
        end else begin
          outstanding_next = out_upd;
          // Leave on the cycle the final response arrives.
          if (out_upd == '0) begin
            state_next = IDLE;
            last_next  = owner;
            gnt_next   = 2'b00;
          end
        end
      end

      default: begin
        state_next       = IDLE;
        outstanding_next = '0;
        gnt_next         = 2'b00;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;   // B, so A wins the first tie
      outstanding <= '0;
      count       <= '0;
      gnt         <= 2'b00;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last        <= last_next;
      outstanding <= outstanding_next;
      count       <= count_next;
      gnt         <= gnt_next;
    end
  end

endmodule
